gpio_input_port: RTL

//  Parametrised memory-mapped input peripheral for the multicycle CPU; supersedes the fixed 8-bit

---
 rtl/gpio_input_port.sv | 121 ++++++++++++
 1 files changed

// File: rtl/gpio_input_port.sv
// Memory-mapped debounced GPIO input port with sticky edge events, mask, irq and edge counter.
// Optional FALLING_EDGE_EN: falling edges also qualify as events and count.
module gpio_input_port #(
  parameter int CHANNELS        = 8,
  parameter int DATA_W          = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in_raw,
  input  logic [1:0]          cpu_addr,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                irq
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] lvl_q, lvl_d;
  logic [CNT_W-1:0]    dbc_q [CHANNELS];
  logic [CNT_W-1:0]    dbc_d [CHANNELS];
  logic [CHANNELS-1:0] evt_q, evt_d;
  logic [CHANNELS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [CHANNELS-1:0] edge_hit;
  logic [CHANNELS-1:0] w1c;
  logic [DATA_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   lvl_x, evt_x, mask_x;
  logic                wr_evt, wr_mask, wr_cnt;

  // counter runs only while the synced pin disagrees with the accepted level
  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < CHANNELS; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
`ifdef FALLING_EDGE_EN
    edge_hit = lvl_d ^ lvl_q;
`else
    edge_hit = lvl_d & ~lvl_q;
`endif
    edge_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      edge_cnt = edge_cnt + DATA_W'(edge_hit[i]);
    end
  end

  always_comb begin
    wr_evt  = cpu_wr && (cpu_addr == 2'd1);
    wr_mask = cpu_wr && (cpu_addr == 2'd2);
    wr_cnt  = cpu_wr && (cpu_addr == 2'd3);
    w1c     = wr_evt ? cpu_wdata[CHANNELS-1:0] : '0;
    evt_d   = (evt_q & ~w1c) | edge_hit;
    mask_d  = wr_mask ? cpu_wdata[CHANNELS-1:0] : mask_q;
    count_d = wr_cnt ? cpu_wdata : count_q + edge_cnt;
  end

  always_comb begin
    lvl_x  = '0;
    evt_x  = '0;
    mask_x = '0;
    lvl_x[CHANNELS-1:0]  = lvl_q;
    evt_x[CHANNELS-1:0]  = evt_q;
    mask_x[CHANNELS-1:0] = mask_q;
    rdata_d = rdata_q;
    if (cpu_rd) begin
      unique case (cpu_addr)
        2'd0: rdata_d = lvl_x;
        2'd1: rdata_d = evt_x;
        2'd2: rdata_d = mask_x;
        2'd3: rdata_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      evt_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        dbc_q[i] <= '0;
      end
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_d;
      evt_q   <= evt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < CHANNELS; i++) begin
        dbc_q[i] <= dbc_d[i];
      end
    end
  end

  assign cpu_rdata = rdata_q;
  assign irq       = |(evt_q & mask_q);

endmodule
